// File: rtl/wide_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : wide_alu_seq
// Brief    : Issues one WORDS-byte ADD/SUB/LSL/LSR to an 8-bit ALU, one byte
//            per cycle, chaining the carry/shift bit between bytes.
// Revision : 1.0 - initial release
// ============================================================================
module wide_alu_seq #(
    parameter int WORDS = 2,
    localparam int W    = 8 * WORDS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [4:0]   alu_cmd,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic         alu_sc_i,
    input  logic [7:0]   alu_rslt,
    input  logic         alu_sc_o,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         zero
);

    localparam int         IDXW     = $clog2(WORDS);
    localparam logic [1:0] c_OP_ADD = 2'd0;
    localparam logic [1:0] c_OP_SUB = 2'd1;
    localparam logic [1:0] c_OP_LSL = 2'd2;
    localparam logic [1:0] c_OP_LSR = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDXW-1:0] r_idx;
    logic            r_c;
    logic [1:0]      r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    r_result;
    logic            r_carry;
    logic            r_zero;

    logic            w_accept;
    logic            w_last;
    logic [IDXW-1:0] w_k;
    logic [7:0]      w_a_byte;
    logic [7:0]      w_b_byte;
    logic [W-1:0]    w_acc_nxt;

    assign w_accept = (r_state != S_RUN) && start;
    assign w_last   = (r_idx == IDXW'(WORDS - 1));
    // LSR walks bytes high to low so the shifted-out bit flows downward
    assign w_k      = (r_op == c_OP_LSR) ? (IDXW'(WORDS - 1) - r_idx) : r_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_state_nxt = start ? S_RUN : S_IDLE;
            S_RUN:          w_state_nxt = w_last ? S_DONE : S_RUN;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_a_byte  = 8'h00;
        w_b_byte  = 8'h00;
        w_acc_nxt = r_acc;
        for (int i = 0; i < WORDS; i++) begin
            if (w_k == IDXW'(i)) begin
                w_a_byte            = r_a[i*8 +: 8];
                w_b_byte            = r_b[i*8 +: 8];
                w_acc_nxt[i*8 +: 8] = alu_rslt;
            end
        end
    end

    always_comb begin
        alu_cmd  = 5'h0F;
        alu_a    = 8'h00;
        alu_b    = 8'h00;
        alu_sc_i = 1'b0;
        if (r_state == S_RUN) begin
            alu_a    = w_a_byte;
            alu_sc_i = r_c;
            case (r_op)
                c_OP_ADD: begin
                    alu_cmd = 5'h00;
                    alu_b   = w_b_byte;
                end
                // a - b computed as a + ~b + 1 with the +1 seeded into r_c
                c_OP_SUB: begin
                    alu_cmd = 5'h00;
                    alu_b   = ~w_b_byte;
                end
                c_OP_LSL: alu_cmd = 5'h06;
                default:  alu_cmd = 5'h07;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx    <= '0;
            r_c      <= 1'b0;
            r_op     <= 2'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_op  <= op;
            r_idx <= '0;
            r_c   <= (op == c_OP_SUB);
            r_acc <= '0;
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_nxt;
            r_c   <= alu_sc_o;
            if (w_last) begin
                r_idx    <= '0;
                r_result <= w_acc_nxt;
                r_carry  <= alu_sc_o;
                r_zero   <= (w_acc_nxt == '0);
            end else begin
                r_idx <= r_idx + IDXW'(1);
            end
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign carry_out = r_carry;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_wide_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_wide_alu_seq
// Brief    : Self-checking bench for wide_alu_seq with a behavioural 8-bit ALU
//            and a queue of expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wide_alu_seq;

    localparam int WORDS = 2;
    localparam int W     = 8 * WORDS;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         z;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   alu_cmd;
    logic [7:0]   alu_a;
    logic [7:0]   alu_b;
    logic         alu_sc_i;
    logic [7:0]   alu_rslt;
    logic         alu_sc_o;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;

    int   total;
    int   bad;
    int   cyc;
    int   t0;
    exp_t exp_q[$];

    wide_alu_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .alu_cmd   (alu_cmd),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sc_i  (alu_sc_i),
        .alu_rslt  (alu_rslt),
        .alu_sc_o  (alu_sc_o),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 00 add with carry-in, 06 shift left, 07 shift right
    always_comb begin
        alu_rslt = 8'h00;
        alu_sc_o = 1'b0;
        case (alu_cmd)
            5'h00:   {alu_sc_o, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_sc_i};
            5'h06:   {alu_sc_o, alu_rslt} = {alu_a, alu_sc_i};
            5'h07:   {alu_rslt, alu_sc_o} = {alu_sc_i, alu_a};
            default: ;
        endcase
    end

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t     e;
        logic [W:0] s;
        case (o)
            2'd0: begin s = {1'b0, x} + {1'b0, y}; e.r = s[W-1:0]; e.c = s[W]; end
            2'd1: begin e.r = x - y; e.c = (x >= y); end
            2'd2: begin e.r = x << 1; e.c = x[W-1]; end
            default: begin e.r = x >> 1; e.c = x[0]; end
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(model(o, x, y));
        t0 = cyc;
        step();
        start = 1'b0;
        op    = 2'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    task automatic collect(input string tag);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int n = 0; n < 12; n++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_done_timeout got=none exp=done", tag);
        end else begin
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s_queue got=empty exp=entry", tag);
            end else begin
                e = exp_q.pop_front();
                if (cyc - t0 !== WORDS + 1) begin
                    bad++;
                    $display("FAIL %s_latency got=%0d exp=%0d", tag, cyc - t0, WORDS + 1);
                end
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_busy_at_done got=%b exp=0", tag, busy);
                end
                total++;
                if (result !== e.r) begin
                    bad++;
                    $display("FAIL %s_result got=%h exp=%h", tag, result, e.r);
                end
                total++;
                if (carry_out !== e.c) begin
                    bad++;
                    $display("FAIL %s_carry got=%b exp=%b", tag, carry_out, e.c);
                end
                total++;
                if (zero !== e.z) begin
                    bad++;
                    $display("FAIL %s_zero got=%b exp=%b", tag, zero, e.z);
                end
            end
        end
    endtask

    task automatic test_reset();
        total++;
        if ({busy, done, carry_out, zero} !== 4'b0000 || result !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b%b%b%b/%h exp=0000/0000", busy, done, carry_out, zero, result);
        end
        total++;
        if (alu_cmd !== 5'h0F || alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sc_i !== 1'b0) begin
            bad++;
            $display("FAIL reset_alu got=%h/%h/%h/%b exp=0f/00/00/0", alu_cmd, alu_a, alu_b, alu_sc_i);
        end
    endtask

    task automatic test_add();
        issue(2'd0, 16'h00FF, 16'h0001);
        total++;
        if (busy !== 1'b1 || alu_cmd !== 5'h00 || alu_a !== 8'hFF || alu_b !== 8'h01 || alu_sc_i !== 1'b0) begin
            bad++;
            $display("FAIL add_byte0 got=%b/%h/%h/%h/%b exp=1/00/ff/01/0", busy, alu_cmd, alu_a, alu_b, alu_sc_i);
        end
        total++;
        if (result !== 16'h0000) begin
            bad++;
            $display("FAIL add_result_held_busy got=%h exp=0000", result);
        end
        step();
        total++;
        if (busy !== 1'b1 || alu_cmd !== 5'h00 || alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sc_i !== 1'b1) begin
            bad++;
            $display("FAIL add_byte1 got=%b/%h/%h/%h/%b exp=1/00/00/00/1", busy, alu_cmd, alu_a, alu_b, alu_sc_i);
        end
        collect("add");
        step();
        total++;
        if (done !== 1'b0 || result !== 16'h0100) begin
            bad++;
            $display("FAIL add_hold got=%b/%h exp=0/0100", done, result);
        end
    endtask

    task automatic test_wrap_sub();
        issue(2'd0, 16'hFFFF, 16'h0001);
        collect("add_wrap");
        issue(2'd1, 16'h0100, 16'h0001);
        collect("sub_nb");
    endtask

    task automatic test_sub_borrow();
        issue(2'd1, 16'h0000, 16'h0001);
        total++;
        if (alu_cmd !== 5'h00 || alu_b !== 8'hFE || alu_sc_i !== 1'b1) begin
            bad++;
            $display("FAIL sub_byte0 got=%h/%h/%b exp=00/fe/1", alu_cmd, alu_b, alu_sc_i);
        end
        step();
        total++;
        if (alu_b !== 8'hFF) begin
            bad++;
            $display("FAIL sub_byte1 got=%h exp=ff", alu_b);
        end
        collect("sub_borrow");
    endtask

    task automatic test_shifts();
        issue(2'd2, 16'h8001, 16'h5555);
        total++;
        if (alu_cmd !== 5'h06 || alu_a !== 8'h01 || alu_b !== 8'h00) begin
            bad++;
            $display("FAIL lsl_byte0 got=%h/%h/%h exp=06/01/00", alu_cmd, alu_a, alu_b);
        end
        collect("lsl");
        issue(2'd3, 16'h8001, 16'hAAAA);
        total++;
        if (alu_cmd !== 5'h07 || alu_a !== 8'h80) begin
            bad++;
            $display("FAIL lsr_byte0 got=%h/%h exp=07/80", alu_cmd, alu_a);
        end
        step();
        total++;
        if (alu_a !== 8'h01) begin
            bad++;
            $display("FAIL lsr_byte1 got=%h exp=01", alu_a);
        end
        collect("lsr");
    endtask

    task automatic test_back_to_back();
        issue(2'd0, 16'h0005, 16'h0003);
        start = 1'b1;
        op    = 2'd1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        step();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || result !== 16'h4000) begin
            bad++;
            $display("FAIL ignore_busy got=%b/%h exp=1/4000", busy, result);
        end
        collect("ignore");
        issue(2'd0, 16'h1234, 16'h1111);
        collect("b2b");
    endtask

    task automatic test_reset_abort();
        bit any_done;
        issue(2'd0, 16'h0010, 16'h0020);
        reset = 1'b1;
        step();
        reset = 1'b0;
        void'(exp_q.pop_back());
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || carry_out !== 1'b0 || zero !== 1'b0 || alu_cmd !== 5'h0F) begin
            bad++;
            $display("FAIL abort_state got=%b/%b/%h/%b/%b/%h exp=0/0/0000/0/0/0f", busy, done, result, carry_out, zero, alu_cmd);
        end
        any_done = 1'b0;
        for (int n = 0; n < 5; n++) begin
            if (done === 1'b1) any_done = 1'b1;
            step();
        end
        total++;
        if (any_done) begin
            bad++;
            $display("FAIL abort_no_done got=1 exp=0");
        end
        issue(2'd0, 16'h0001, 16'h0002);
        collect("after_abort");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        t0    = 0;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        a     = '0;
        b     = '0;
        step();
        step();
        reset = 1'b0;
        step();
        test_reset();
        test_add();
        test_wrap_sub();
        test_sub_borrow();
        test_shifts();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wide_alu_seq.md
# wide_alu_seq

Multi-byte operation sequencer for the 8-bit combinational ALU. It accepts one WORDS-byte operation per start pulse and issues it to the ALU one byte per cycle, chaining the shift/carry bit between bytes. It collects the result bytes, then reports result, carry and zero with a one-cycle done pulse. It sits between the core control path and the ALU, which it owns exclusively while busy.

## Interface
- WORDS, 2, operand width in bytes (≥2); data width W = 8*WORDS
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on clk rising edge
- start  in  1  request; accepted only when busy=0
- op  in  2  operation: 0 ADD, 1 SUB (a−b), 2 LSL by 1, 3 LSR by 1
- a, b  in  W  operands, sampled on the accepting edge only (b ignored for shifts)
- alu_cmd  out  5  command to ALU
- alu_a, alu_b  out  8  byte operands to ALU
- alu_sc_i  out  1  shift/carry into ALU
- alu_rslt  in  8  ALU result byte
- alu_sc_o  in  1  ALU shift/carry out
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- result  out  W  final result, held until next accepted start
- carry_out  out  1  final chained carry/shift-out bit, held with result
- zero  out  1  result == 0, held with result

## Operation
- States: IDLE, RUN, DONE. Byte index idx counts 0..WORDS−1; carry register c holds the chain bit.
- IDLE/DONE: start=1 → latch a, b, op; idx=0; set the initial c; go to RUN. Otherwise IDLE/DONE → IDLE.
- Initial c: ADD 0, SUB 1, LSL 0, LSR 0.
- RUN, byte k in order: ADD/SUB/LSL low→high (k=idx); LSR high→low (k=WORDS−1−idx).
- ALU drive in RUN:
  - ADD: alu_cmd=5'h00, alu_a=a[k], alu_b=b[k], alu_sc_i=c.
  - SUB: alu_cmd=5'h00 (ADD), alu_b=~b[k], alu_sc_i=c. Subtraction is a + ~b + 1. The ALU SUB command is not used.
  - LSL: alu_cmd=5'h06, alu_a=a[k], alu_b=0, alu_sc_i=c.
  - LSR: alu_cmd=5'h07, alu_a=a[k], alu_b=0, alu_sc_i=c.
- Each RUN edge: result byte k ← alu_rslt; c ← alu_sc_o; idx+1. When idx=WORDS−1, go to DONE.
- DONE: done=1 for exactly that cycle. carry_out=c, zero=(result==0).
- Not in RUN: alu_cmd=5'h0F (ALU no-op default), alu_a=alu_b=0, alu_sc_i=0.
- carry_out meaning:
  - ADD: carry out of the MSB.
  - SUB: 1 = no borrow (a ≥ b unsigned), 0 = borrow.
  - LSL: old bit W−1.
  - LSR: old bit 0.
- Shifts fill with 0.
- All arithmetic is unsigned modulo 2^W.

## Timing
- Reset: state IDLE; busy=0, done=0, result=0, carry_out=0, zero=0, idx=0, c=0. ALU outputs at idle values.
- Reset mid-RUN or in DONE aborts immediately. No done pulse; result, carry_out and zero clear to 0. Reset wins over a simultaneous start.
- Latency: start high in cycle 0 → busy high cycles 1..WORDS → done high in cycle WORDS+1 with busy=0. Result, carry_out and zero are valid from cycle WORDS+1.
- Throughput: start may be asserted in the DONE cycle. It is accepted and RUN begins in the next cycle; back-to-back issue interval is WORDS+1 cycles.
- start while busy=1 is ignored: no queuing, latched operands unchanged.
- a, b and op may change freely after the accepting edge.
- result, carry_out and zero are unchanged while busy. They update to new values only on the RUN→DONE transition.
- ALU path is combinational within a RUN cycle. alu_rslt/alu_sc_o must settle within the same clk period.

## Test plan
- WORDS=2, ADD a=16'h00FF b=16'h0001 → alu_cmd 00,00 over cycles 1–2; done in cycle 3; result 16'h0100, carry_out 0, zero 0.
- ADD a=16'hFFFF b=16'h0001 → result 16'h0000, carry_out 1, zero 1. Then SUB 16'h0100−16'h0001 → 16'h00FF, carry_out 1.
- SUB a=16'h0000 b=16'h0001 → result 16'hFFFF, carry_out 0 (borrow). Check alu_b=8'hFE then 8'hFF and alu_sc_i=1 on the first byte.
- LSL a=16'h8001 → 16'h0002, carry_out 1. LSR a=16'h8001 → 16'h4000, carry_out 1; bytes issued high first: alu_a=8'h80 then 8'h01.
- Start pulsed in cycle 1 of an ADD with different operands → ignored; original result delivered in cycle 3. Start in the DONE cycle → accepted, second done 3 cycles later.
- Reset asserted in cycle 1 of RUN → next cycle IDLE, busy=0, result=0, no done pulse. A new ADD then completes normally.
